// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage of the five-stage MIPS pipeline.
// Latency: the word at pc reaches if_id_instr on the next clk edge; a redirect costs one bubble.
// Backpressure: stall holds pc, IF/ID and fetch_count; a redirect overrides stall.
//
// Holds the fetch PC, drives the instruction-memory address combinationally
// from it, and registers the fetched word plus its PC+4 into the IF/ID
// pipeline register. Redirects (jr, beq/bne, j/jal) are resolved in ID.
//
// Optional feature, macro FETCH_HALT_EN: fetching HALT_WORD stops the stage
// until reset. Without the macro, halted is tied low and HALT_WORD is
// fetched as an ordinary instruction.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   stall               hazard-unit hold of pc and IF/ID
//   jr_taken/target     register-sourced redirect (highest priority)
//   branch_taken/target conditional-branch redirect
//   jump_taken/target   j/jal redirect (lowest priority)
//   imem_addr/rdata     instruction memory, combinational read
//   pc                  current fetch PC
//   if_id_*             IF/ID pipeline register (instr, pc4, valid)
//   fetch_count         instructions written valid into IF/ID
//   halted              fetch stopped on the sentinel word

module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        jr_taken,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] pc_q;
  logic [31:0] pc4;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt_hit;

  // Next-value / enable signals produced by the output process
  logic        pc_ld;
  logic [31:0] pc_d;
  logic        ifid_ld;
  logic [31:0] ifid_instr_d;
  logic [31:0] ifid_pc4_d;
  logic        ifid_valid_d;
  logic        cnt_inc;

  assign pc4      = pc_q + 32'd4;   // natural 32-bit wrap: FFFF_FFFC -> 0
  assign redirect = jr_taken | branch_taken | jump_taken;

  // Only one source is legal at a time; the fixed order just makes the
  // illegal multi-assert case deterministic.
  always_comb begin
    redirect_target = jump_target;
    if (jr_taken) begin
      redirect_target = jr_target;
    end else if (branch_taken) begin
      redirect_target = branch_target;
    end
  end

  // Sentinel detection only counts on a cycle that would really retire the
  // word: a same-cycle redirect marks it wrong-path, a stall postpones it.
`ifdef FETCH_HALT_EN
  assign halt_hit = ~redirect & ~stall & (imem_rdata == HALT_WORD);
`else
  assign halt_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic. HALT is absorbing; only reset leaves it.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_hit) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output logic -- decides what pc, IF/ID and the counter load.
  // ---------------------------------------------------------------------
  always_comb begin
    pc_ld        = 1'b0;
    pc_d         = pc_q;
    ifid_ld      = 1'b0;
    ifid_instr_d = 32'h0;
    ifid_pc4_d   = 32'h0;
    ifid_valid_d = 1'b0;
    cnt_inc      = 1'b0;

    case (state_q)
      RUN: begin
        if (redirect) begin
          // The word fetched at the old pc is wrong-path: squash it.
          pc_ld   = 1'b1;
          pc_d    = redirect_target;
          ifid_ld = 1'b1;
        end else if (stall) begin
          // Everything holds; nothing to load.
          pc_ld   = 1'b0;
        end else if (halt_hit) begin
          // pc parks on the sentinel address; sentinel never retires.
          ifid_ld = 1'b1;
        end else begin
          pc_ld        = 1'b1;
          pc_d         = pc4;
          ifid_ld      = 1'b1;
          ifid_instr_d = imem_rdata;
          ifid_pc4_d   = pc4;
          ifid_valid_d = 1'b1;
          cnt_inc      = 1'b1;
        end
      end
      HALT: begin
        // Stall and redirects are ignored; keep feeding bubbles.
        ifid_ld = 1'b1;
      end
      default: begin
        ifid_ld = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // PC register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else if (pc_ld) begin
      pc_q <= pc_d;
    end
  end

  // ---------------------------------------------------------------------
  // IF/ID pipeline register. A bubble is instr 0 (sll $0,$0,0), pc4 0,
  // valid 0, so decode sees a harmless nop even if valid were ignored.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (ifid_ld) begin
      if_id_instr <= ifid_instr_d;
      if_id_pc4   <= ifid_pc4_d;
      if_id_valid <= ifid_valid_d;
    end
  end

  // ---------------------------------------------------------------------
  // Retired-fetch counter, wraps naturally at 2^32.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= 32'h0;
    end else if (cnt_inc) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;

`ifdef FETCH_HALT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        jr_taken;
  logic [31:0] jr_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic        halted;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic sentinel_en;

  instr_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .jr_taken     (jr_taken),
    .jr_target    (jr_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump_taken   (jump_taken),
    .jump_target  (jump_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .fetch_count  (fetch_count),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: returns its own address, except the sentinel at 0x20.
  always_comb begin
    imem_rdata = imem_addr;
    if (sentinel_en && imem_addr == 32'h20) imem_rdata = 32'hFFFF_FFFF;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects;
    jr_taken = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; stall = 1'b0; sentinel_en = 1'b0;
    clear_redirects();
    jr_target = 32'h0; branch_target = 32'h0; jump_target = 32'h0;
    #2;
    vec_cnt++; if (pc !== 32'h0) begin err_cnt++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    vec_cnt++; if (if_id_instr !== 32'h0) begin err_cnt++; $display("FAIL reset_instr: got %h want %h", if_id_instr, 32'h0); end
    vec_cnt++; if (if_id_pc4 !== 32'h0) begin err_cnt++; $display("FAIL reset_pc4: got %h want %h", if_id_pc4, 32'h0); end
    vec_cnt++; if (if_id_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    vec_cnt++; if (fetch_count !== 32'h0) begin err_cnt++; $display("FAIL reset_count: got %h want 0", fetch_count); end
    vec_cnt++; if (halted !== 1'b0) begin err_cnt++; $display("FAIL reset_halted: got %b want 0", halted); end
    // Clock edges while reset is held must not advance anything.
    tick(); tick();
    vec_cnt++; if (pc !== 32'h0) begin err_cnt++; $display("FAIL reset_hold_pc: got %h want %h", pc, 32'h0); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Two fetches from reset, then 3 stalled cycles at pc=8, then resume.
  task automatic test_fetch_and_stall;
    logic [31:0] exp_instr [0:1];
    exp_instr[0] = 32'h0; exp_instr[1] = 32'h4;
    for (int k = 0; k < 2; k++) begin
      tick();
      vec_cnt++; if (if_id_instr !== exp_instr[k]) begin err_cnt++; $display("FAIL fetch_instr%0d: got %h want %h", k, if_id_instr, exp_instr[k]); end
      vec_cnt++; if (if_id_pc4 !== exp_instr[k] + 32'd4) begin err_cnt++; $display("FAIL fetch_pc4%0d: got %h want %h", k, if_id_pc4, exp_instr[k] + 32'd4); end
      vec_cnt++; if (if_id_valid !== 1'b1) begin err_cnt++; $display("FAIL fetch_valid%0d: got %b want 1", k, if_id_valid); end
      vec_cnt++; if (fetch_count !== k + 1) begin err_cnt++; $display("FAIL fetch_count%0d: got %0d want %0d", k, fetch_count, k + 1); end
    end
    vec_cnt++; if (imem_addr !== 32'h8) begin err_cnt++; $display("FAIL imem_addr: got %h want %h", imem_addr, 32'h8); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if (pc !== 32'h8) begin err_cnt++; $display("FAIL stall_pc%0d: got %h want %h", i, pc, 32'h8); end
      vec_cnt++; if (if_id_instr !== 32'h4 || if_id_valid !== 1'b1) begin err_cnt++; $display("FAIL stall_ifid%0d: got %h/%b want 00000004/1", i, if_id_instr, if_id_valid); end
      vec_cnt++; if (fetch_count !== 32'd2) begin err_cnt++; $display("FAIL stall_count%0d: got %0d want 2", i, fetch_count); end
    end
    stall = 1'b0;
    tick();
    vec_cnt++; if (if_id_instr !== 32'h8 || if_id_pc4 !== 32'hC) begin err_cnt++; $display("FAIL resume_ifid: got %h/%h want 00000008/0000000c", if_id_instr, if_id_pc4); end
    vec_cnt++; if (fetch_count !== 32'd3) begin err_cnt++; $display("FAIL resume_count: got %0d want 3", fetch_count); end
    tick();
    vec_cnt++; if (pc !== 32'h10 || if_id_instr !== 32'hC) begin err_cnt++; $display("FAIL resume2: got pc %h instr %h want 00000010/0000000c", pc, if_id_instr); end
  endtask

  // Branch at pc=0x10 to 0x40: one bubble then the target word.
  task automatic test_branch;
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    clear_redirects();
    vec_cnt++; if (pc !== 32'h40) begin err_cnt++; $display("FAIL br_pc: got %h want %h", pc, 32'h40); end
    vec_cnt++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin err_cnt++; $display("FAIL br_bubble: got %h/%h/%b want 0/0/0", if_id_instr, if_id_pc4, if_id_valid); end
    vec_cnt++; if (fetch_count !== 32'd4) begin err_cnt++; $display("FAIL br_count: got %0d want 4", fetch_count); end
    tick();
    vec_cnt++; if (if_id_instr !== 32'h40 || if_id_pc4 !== 32'h44 || if_id_valid !== 1'b1) begin err_cnt++; $display("FAIL br_target: got %h/%h/%b want 00000040/00000044/1", if_id_instr, if_id_pc4, if_id_valid); end
    vec_cnt++; if (fetch_count !== 32'd5) begin err_cnt++; $display("FAIL br_count2: got %0d want 5", fetch_count); end
  endtask

  // All three redirect sources with stall: jr wins and stall is overridden.
  task automatic test_priority;
    stall = 1'b1;
    jr_taken = 1'b1; jr_target = 32'h100;
    branch_taken = 1'b1; branch_target = 32'h200;
    jump_taken = 1'b1; jump_target = 32'h300;
    tick();
    vec_cnt++; if (pc !== 32'h100) begin err_cnt++; $display("FAIL prio_all_pc: got %h want %h", pc, 32'h100); end
    vec_cnt++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin err_cnt++; $display("FAIL prio_bubble: got %h/%b want 0/0", if_id_instr, if_id_valid); end
    jr_taken = 1'b0;
    tick();
    vec_cnt++; if (pc !== 32'h200) begin err_cnt++; $display("FAIL prio_br_pc: got %h want %h", pc, 32'h200); end
    branch_taken = 1'b0; stall = 1'b0;
    jump_target = 32'h1002;
    tick();
    clear_redirects();
    vec_cnt++; if (pc !== 32'h1002) begin err_cnt++; $display("FAIL jump_unaligned_pc: got %h want %h", pc, 32'h1002); end
    vec_cnt++; if (fetch_count !== 32'd5) begin err_cnt++; $display("FAIL prio_count: got %0d want 5", fetch_count); end
    tick();
    vec_cnt++; if (pc !== 32'h1006 || if_id_instr !== 32'h1002 || if_id_pc4 !== 32'h1006) begin err_cnt++; $display("FAIL unaligned_fetch: got pc %h instr %h pc4 %h want 00001006/00001002/00001006", pc, if_id_instr, if_id_pc4); end
    vec_cnt++; if (fetch_count !== 32'd6) begin err_cnt++; $display("FAIL unaligned_count: got %0d want 6", fetch_count); end
  endtask

  // PC wrap, then async reset asserted mid-cycle during a stall + redirect.
  task automatic test_wrap_and_async_reset;
    jr_taken = 1'b1; jr_target = 32'hFFFF_FFFC;
    tick();
    jr_taken = 1'b0;
    vec_cnt++; if (pc !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL wrap_pre_pc: got %h want fffffffc", pc); end
    tick();
    vec_cnt++; if (pc !== 32'h0 || if_id_pc4 !== 32'h0) begin err_cnt++; $display("FAIL wrap: got pc %h pc4 %h want 0/0", pc, if_id_pc4); end
    vec_cnt++; if (if_id_instr !== 32'hFFFF_FFFC || if_id_valid !== 1'b1) begin err_cnt++; $display("FAIL wrap_instr: got %h/%b want fffffffc/1", if_id_instr, if_id_valid); end
    tick();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h500;
    #2;
    reset_n = 1'b0;
    #1;
    vec_cnt++; if (pc !== 32'h0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0) begin err_cnt++; $display("FAIL async_rst_regs: got pc %h instr %h pc4 %h valid %b want 0/0/0/0", pc, if_id_instr, if_id_pc4, if_id_valid); end
    vec_cnt++; if (fetch_count !== 32'h0 || halted !== 1'b0) begin err_cnt++; $display("FAIL async_rst_cnt: got %0d/%b want 0/0", fetch_count, halted); end
    clear_redirects(); stall = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Sentinel at 0x20: same-cycle redirect wins, stall defers, then halt.
  task automatic test_halt;
    sentinel_en = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    vec_cnt++; if (pc !== 32'h20 || fetch_count !== 32'd8) begin err_cnt++; $display("FAIL halt_pre: got pc %h cnt %0d want 00000020/8", pc, fetch_count); end
    branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    vec_cnt++; if (pc !== 32'h80 || halted !== 1'b0) begin err_cnt++; $display("FAIL halt_redirect_wins: got pc %h halted %b want 00000080/0", pc, halted); end
    jr_taken = 1'b1; jr_target = 32'h20;
    tick();
    jr_taken = 1'b0; stall = 1'b1;
    tick();
    vec_cnt++; if (pc !== 32'h20 || halted !== 1'b0) begin err_cnt++; $display("FAIL halt_stall_defer: got pc %h halted %b want 00000020/0", pc, halted); end
    stall = 1'b0;
    tick();
`ifdef FETCH_HALT_EN
    vec_cnt++; if (halted !== 1'b1 || pc !== 32'h20) begin err_cnt++; $display("FAIL halt_enter: got halted %b pc %h want 1/00000020", halted, pc); end
    vec_cnt++; if (if_id_valid !== 1'b0 || fetch_count !== 32'd8) begin err_cnt++; $display("FAIL halt_bubble: got valid %b cnt %0d want 0/8", if_id_valid, fetch_count); end
    branch_taken = 1'b1; branch_target = 32'h40;
    tick(); tick();
    branch_taken = 1'b0;
    vec_cnt++; if (pc !== 32'h20 || halted !== 1'b1 || if_id_valid !== 1'b0) begin err_cnt++; $display("FAIL halt_ignores_redirect: got pc %h halted %b valid %b want 00000020/1/0", pc, halted, if_id_valid); end
`else
    vec_cnt++; if (halted !== 1'b0 || pc !== 32'h24) begin err_cnt++; $display("FAIL sentinel_plain: got halted %b pc %h want 0/00000024", halted, pc); end
    vec_cnt++; if (if_id_instr !== 32'hFFFF_FFFF || if_id_valid !== 1'b1 || fetch_count !== 32'd9) begin err_cnt++; $display("FAIL sentinel_retire: got %h/%b/%0d want ffffffff/1/9", if_id_instr, if_id_valid, fetch_count); end
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    vec_cnt++; if (pc !== 32'h40 || halted !== 1'b0) begin err_cnt++; $display("FAIL sentinel_redirect: got pc %h halted %b want 00000040/0", pc, halted); end
`endif
    sentinel_en = 1'b0;
    do_reset();
    vec_cnt++; if (halted !== 1'b0 || pc !== 32'h0) begin err_cnt++; $display("FAIL halt_exit_reset: got halted %b pc %h want 0/0", halted, pc); end
    tick();
    vec_cnt++; if (pc !== 32'h4 || if_id_valid !== 1'b1) begin err_cnt++; $display("FAIL post_reset_fetch: got pc %h valid %b want 00000004/1", pc, if_id_valid); end
  endtask

  initial begin
    test_reset();
    test_fetch_and_stall();
    test_branch();
    test_priority();
    test_wrap_and_async_reset();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, got no finish want finish");
    $fatal(1);
  end

endmodule
